// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: oversample edge/bit counters, frame FSM,
// one-cycle strobes to the sampler/checkers/deserializer, and frame-accept strobe.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);

  localparam int unsigned PW = PRESCALE_W;
  localparam int unsigned BW = BIT_CNT_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] p_q, p_nxt;
  logic [PW-1:0] edge_nxt;
  logic [BW-1:0] bit_nxt;
  logic          dv_nxt;

  logic [PW-1:0] strb_edge, last_edge;
  logic          at_strb, at_last;

  // Strobe one cycle after the sampler's third vote at H+1; decide at the last edge.
  assign strb_edge = (p_q >> 1) + PW'(2);
  assign last_edge = p_q - PW'(1);
  assign at_strb   = (edge_cnt == strb_edge);
  assign at_last   = (edge_cnt == last_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      p_q        <= PW'(8);
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      p_q        <= p_nxt;
      edge_cnt   <= edge_nxt;
      bit_cnt    <= bit_nxt;
      data_valid <= dv_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    p_nxt       = p_q;
    dv_nxt      = 1'b0;
    edge_nxt    = '0;
    bit_nxt     = '0;
    dat_samp_en = (state != IDLE);
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;

    if (state != IDLE) begin
      edge_nxt = at_last ? '0 : edge_cnt + PW'(1);
      bit_nxt  = at_last ? bit_cnt + BW'(1) : bit_cnt;
    end

    case (state)
      IDLE: begin
        if (!rx_in) begin
          state_nxt = START;
          p_nxt     = prescale;
        end
      end
      START: begin
        strt_chk_en = at_strb;
        if (at_last) state_nxt = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser_en = at_strb;
        if (at_last && (bit_cnt == BW'(DATA_WIDTH))) state_nxt = par_en ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = at_strb;
        if (at_last) state_nxt = par_err ? IDLE : STOP;
      end
      STOP: begin
        stp_chk_en = at_strb;
        if (at_last) begin
          state_nxt = IDLE;
          dv_nxt    = !stp_err;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Counters sit at zero for the whole of IDLE, including the cycle after an abort.
    if (state_nxt == IDLE) begin
      edge_nxt = '0;
      bit_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives serial frames and checker flags,
// records strobe positions and data_valid latency, compares with hand values.
module tb_uart_rx_ctrl;

  localparam int unsigned PW = 6;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic [PW-1:0] prescale;
  logic          strt_glitch, par_err, stp_err;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int start_cyc;
  int n_deser, deser_bad, n_strt, strt_edge, n_par, par_bit, par_edge;
  int n_stp, stp_bit, n_dv, dv_lat, idle_rel;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode: 0 clean, 1 par_err after par check, 2 stp_err after stop check, 3 short start glitch
  task automatic run_frame(input logic [7:0] data, input logic pe, input int p,
                           input int mode, input int ncyc);
    logic [15:0] bits;
    int nbits, s, rel;
    logic seen_act;
    bits = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[j+1] = data[j];
    if (pe) bits[9] = ^data;
    nbits = pe ? 11 : 10;
    s = p / 2 + 2;
    par_en = pe;
    n_deser = 0; deser_bad = 0; n_strt = 0; strt_edge = -1; n_par = 0; par_bit = -1;
    par_edge = -1; n_stp = 0; stp_bit = -1; n_dv = 0; dv_lat = -1; idle_rel = -1;
    seen_act = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (mode == 3) rx_in = (i < 3) ? 1'b0 : 1'b1;
      else           rx_in = ((i / p) < nbits) ? bits[i / p] : 1'b1;
      if (i == 0) begin
        prescale  = PW'(p);
        start_cyc = cyc + 1;
      end
      if (i == 2) prescale = (p == 8) ? PW'(16) : PW'(8);
      @(negedge clk);
      rel = cyc - start_cyc;
      if (deser_en) begin
        n_deser++;
        if (int'(edge_cnt) != s || int'(bit_cnt) != n_deser) deser_bad++;
      end
      if (strt_chk_en) begin n_strt++; strt_edge = int'(edge_cnt); end
      if (par_chk_en) begin n_par++; par_bit = int'(bit_cnt); par_edge = int'(edge_cnt); end
      if (stp_chk_en) begin n_stp++; stp_bit = int'(bit_cnt); end
      if (data_valid) begin n_dv++; dv_lat = rel; end
      if (dat_samp_en) seen_act = 1'b1;
      else if (seen_act && idle_rel < 0) idle_rel = rel;
      if (mode == 3 && strt_chk_en) strt_glitch = 1'b1;
      if (mode == 1 && par_chk_en)  par_err = 1'b1;
      if (mode == 2 && stp_chk_en)  stp_err = 1'b1;
    end
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
  endtask

  task automatic test_reset();
    logic [5+PW+BW-1:0] outs;
    rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = PW'(8);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(negedge clk);
    outs = {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dat_samp_en !== 1'b0) begin bad++; $display("FAIL reset_idle: dat_samp_en got %b want 0", dat_samp_en); end
  endtask

  task automatic test_clean_p8();
    run_frame(8'hA5, 1'b0, 8, 0, 84);
    total++; if (n_deser != 8) begin bad++; $display("FAIL clean_ndeser: got %0d want 8", n_deser); end
    total++; if (deser_bad != 0) begin bad++; $display("FAIL clean_deser_pos: got %0d misplaced want 0", deser_bad); end
    total++; if (n_strt != 1 || strt_edge != 6) begin bad++; $display("FAIL clean_strt: got n=%0d edge=%0d want 1/6", n_strt, strt_edge); end
    total++; if (n_stp != 1 || stp_bit != 9) begin bad++; $display("FAIL clean_stp: got n=%0d bit=%0d want 1/9", n_stp, stp_bit); end
    total++; if (n_par != 0) begin bad++; $display("FAIL clean_npar: got %0d want 0", n_par); end
    total++; if (n_dv != 1 || dv_lat != 80) begin bad++; $display("FAIL clean_dv: got n=%0d lat=%0d want 1/80", n_dv, dv_lat); end
    total++; if (idle_rel != 80) begin bad++; $display("FAIL clean_idle: got %0d want 80", idle_rel); end
  endtask

  task automatic test_parity_p16();
    run_frame(8'h3C, 1'b1, 16, 0, 180);
    total++; if (n_par != 1 || par_bit != 9 || par_edge != 10) begin bad++; $display("FAIL par16_strobe: got n=%0d bit=%0d edge=%0d want 1/9/10", n_par, par_bit, par_edge); end
    total++; if (n_deser != 8 || deser_bad != 0) begin bad++; $display("FAIL par16_deser: got n=%0d bad=%0d want 8/0", n_deser, deser_bad); end
    total++; if (n_stp != 1 || stp_bit != 10) begin bad++; $display("FAIL par16_stp: got n=%0d bit=%0d want 1/10", n_stp, stp_bit); end
    total++; if (n_dv != 1 || dv_lat != 176) begin bad++; $display("FAIL par16_dv: got n=%0d lat=%0d want 1/176", n_dv, dv_lat); end
  endtask

  task automatic test_par_err();
    run_frame(8'h5A, 1'b1, 8, 1, 90);
    total++; if (n_par != 1 || n_deser != 8) begin bad++; $display("FAIL parerr_seq: got par=%0d deser=%0d want 1/8", n_par, n_deser); end
    total++; if (idle_rel != 80) begin bad++; $display("FAIL parerr_idle: got %0d want 80", idle_rel); end
    total++; if (n_stp != 0) begin bad++; $display("FAIL parerr_nstp: got %0d want 0", n_stp); end
    total++; if (n_dv != 0) begin bad++; $display("FAIL parerr_ndv: got %0d want 0", n_dv); end
  endtask

  task automatic test_glitch();
    run_frame(8'h00, 1'b0, 8, 3, 20);
    total++; if (n_strt != 1 || strt_edge != 6) begin bad++; $display("FAIL glitch_strt: got n=%0d edge=%0d want 1/6", n_strt, strt_edge); end
    total++; if (idle_rel != 8) begin bad++; $display("FAIL glitch_idle: got %0d want 8", idle_rel); end
    total++; if (n_deser != 0 || n_dv != 0) begin bad++; $display("FAIL glitch_quiet: got deser=%0d dv=%0d want 0/0", n_deser, n_dv); end
  endtask

  task automatic test_stop_err();
    run_frame(8'hC3, 1'b0, 32, 2, 325);
    total++; if (n_deser != 8 || deser_bad != 0) begin bad++; $display("FAIL stperr_deser: got n=%0d bad=%0d want 8/0", n_deser, deser_bad); end
    total++; if (n_stp != 1 || stp_bit != 9) begin bad++; $display("FAIL stperr_stp: got n=%0d bit=%0d want 1/9", n_stp, stp_bit); end
    total++; if (n_dv != 0 || idle_rel != 320) begin bad++; $display("FAIL stperr_dv: got n=%0d idle=%0d want 0/320", n_dv, idle_rel); end
    run_frame(8'h96, 1'b0, 8, 0, 84);
    total++; if (n_dv != 1 || dv_lat != 80) begin bad++; $display("FAIL stperr_next: got n=%0d lat=%0d want 1/80", n_dv, dv_lat); end
  endtask

  task automatic test_back_to_back();
    run_frame(8'h11, 1'b0, 8, 0, 81);
    total++; if (n_dv != 1 || dv_lat != 80) begin bad++; $display("FAIL b2b_first: got n=%0d lat=%0d want 1/80", n_dv, dv_lat); end
    run_frame(8'hEE, 1'b0, 8, 0, 84);
    total++; if (n_dv != 1 || dv_lat != 80) begin bad++; $display("FAIL b2b_second: got n=%0d lat=%0d want 1/80", n_dv, dv_lat); end
    total++; if (n_deser != 8 || deser_bad != 0) begin bad++; $display("FAIL b2b_deser: got n=%0d bad=%0d want 8/0", n_deser, deser_bad); end
  endtask

  task automatic test_reset_mid_frame();
    logic [5+PW+BW-1:0] outs;
    int noise;
    run_frame(8'hFF, 1'b0, 8, 0, 35);
    total++; if (bit_cnt !== BW'(4) || dat_samp_en !== 1'b1) begin bad++; $display("FAIL midrst_pre: got bit=%0d samp=%b want 4/1", bit_cnt, dat_samp_en); end
    #2 rst = 1'b0;
    #1;
    outs = {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt};
    total++; if (outs !== '0) begin bad++; $display("FAIL midrst_async: got %h want 0", outs); end
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    noise = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dat_samp_en || strt_chk_en || deser_en || par_chk_en || stp_chk_en || data_valid) noise++;
    end
    total++; if (noise != 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", noise); end
    run_frame(8'h42, 1'b0, 16, 0, 164);
    total++; if (strt_edge != 10 || n_deser != 8 || deser_bad != 0) begin bad++; $display("FAIL midrst_p16_strobes: got strt=%0d n=%0d bad=%0d want 10/8/0", strt_edge, n_deser, deser_bad); end
    total++; if (n_dv != 1 || dv_lat != 160) begin bad++; $display("FAIL midrst_p16_dv: got n=%0d lat=%0d want 1/160", n_dv, dv_lat); end
  endtask

  initial begin
    test_reset();
    test_clean_p8();
    test_parity_p16();
    test_par_err();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
